ir_media_ctrl: RTL and testbench
================================

// Module: ir_media_ctrl
// PURPOSE
//   Media-transport controller driven by the IR remote decoder's 8-bit button code.
//   Accepts key events (mute, play/pause, skip, stop) with repeat holdoff.
//   Sequences a STOPPED/PLAYING/PAUSED state machine, a mute flag, a wrapping track index
//   and an elapsed-seconds counter for the VGA display/audio path.
// PARAMETERS
//   NUM_TRACKS  4           number of tracks; track index wraps NUM_TRACKS-1 -> 0
//   TRACK_W     2           width of track index (>= clog2(NUM_TRACKS))
//   TICK_DIV    50_000_000  clk cycles per elapsed second (50 MHz)
//   HOLDOFF     12_500_000  clk cycles after an accepted key during which all keys are ignored
//   SEC_W       12          width of elapsed-seconds counter (saturating)
// PORTS
//   clk          in   1        system clock, 50 MHz
//   rst_n        in   1        asynchronous active-low reset
//   ir_code      in   8        decoder button code: 0x00 mute, 0x01 play/pause, 0x02 skip, 0x03 stop, 0xFF none
//   playing      out  1        1 in PLAYING
//   paused       out  1        1 in PAUSED
//   muted        out  1        mute flag
//   track        out  TRACK_W  current track index
//   track_start  out  1        one-cycle pulse: track (re)starts playing
//   elapsed_s    out  SEC_W    seconds played on current track
//   key_ack      out  1        one-cycle pulse per accepted key
// BEHAVIOUR
//   Reset (async, rst_n=0): state STOPPED; playing=0, paused=0, muted=0, track=0,
//     track_start=0, elapsed_s=0, key_ack=0; holdoff and tick counters = 0; code register = 0xFF.
//     Reset asserted mid-operation aborts everything immediately; no pending key survives.
//   Input: ir_code is registered once (code_q).
//     A key is accepted in the cycle code_q is in 0x00..0x03 and holdoff counter == 0.
//     Codes 0x04..0xFF are never keys.
//   Acceptance: key_ack=1 for that cycle; holdoff loads HOLDOFF-1 and decrements to 0.
//     Keys arriving while holdoff != 0 are dropped, not queued.
//     A code held for many cycles yields exactly one key per HOLDOFF window.
//   Latency: ir_code valid before edge N -> code_q at N -> state/outputs updated at edge N+1.
//   FSM transitions (only on accepted key; otherwise hold):
//     STOPPED + play/pause -> PLAYING, track_start pulse, elapsed_s=0
//     PLAYING + play/pause -> PAUSED
//     PAUSED  + play/pause -> PLAYING (no track_start, elapsed_s kept)
//     any     + stop       -> STOPPED, elapsed_s=0, track unchanged
//     PLAYING + skip       -> track+1 (wrap), elapsed_s=0, tick counter=0, track_start pulse, stay PLAYING
//     PAUSED/STOPPED + skip -> track+1 (wrap), elapsed_s=0, state unchanged, no track_start
//     any     + mute       -> muted toggles; state, track, elapsed_s unchanged
//     Illegal state encoding -> STOPPED next cycle.
//   Elapsed timer: tick counter runs only in PLAYING, counts 0..TICK_DIV-1.
//     Wrap increments elapsed_s, saturating at 2^SEC_W-1.
//     Counter is frozen in PAUSED and cleared in STOPPED.
//     Key and tick wrap in same cycle: key action wins (skip/stop clear; pause freezes after the increment).
//   Track wrap: track==NUM_TRACKS-1 and skip -> 0.
//   Outputs are all registered; playing and paused are never both 1.
// TESTING
//   (TICK_DIV=10, HOLDOFF=20, NUM_TRACKS=4 for all tests)
//   T1 reset: drive activity, pulse rst_n low mid-play -> all outputs 0 same cycle, track=0, STOPPED.
//   T2 play: ir_code=0x01 for 1 cycle -> key_ack 1 cycle, playing=1 and track_start 1 cycle at edge N+1;
//      after 35 cycles elapsed_s=3.
//   T3 holdoff: hold ir_code=0x01 for 50 cycles -> key_ack exactly 3 times (cycles 0,20,40);
//      state PLAYING->PAUSED->PLAYING->PAUSED.
//   T4 skip wrap: play, skip x4 spaced 25 cycles -> track 1,2,3,0, four track_start pulses, elapsed_s=0 after each.
//   T5 pause/stop: play 25 cycles (elapsed_s=2), pause 30 cycles -> elapsed_s stays 2;
//      play -> resumes from 2; stop -> elapsed_s=0, playing=0, track kept.
//   T6 mute/invalid: ir_code=0x00 -> muted=1, state unchanged;
//      ir_code=0x68 or 0xFF for 100 cycles -> no key_ack, no change.

Source files
------------

// File: rtl/ir_media_ctrl.sv
// Media-transport controller: turns registered IR button codes into play/pause/stop/skip/mute
// actions with a repeat holdoff, and keeps a per-track elapsed-seconds count while playing.
module ir_media_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int TRACK_W    = 2,
  parameter int TICK_DIV   = 50_000_000,
  parameter int HOLDOFF    = 12_500_000,
  parameter int SEC_W      = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         ir_code,
  output logic               playing,
  output logic               paused,
  output logic               muted,
  output logic [TRACK_W-1:0] track,
  output logic               track_start,
  output logic [SEC_W-1:0]   elapsed_s,
  output logic               key_ack
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  localparam logic [1:0] ST_STOPPED = 2'b00;
  localparam logic [1:0] ST_PLAYING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  localparam logic [1:0] KEY_MUTE = 2'd0;
  localparam logic [1:0] KEY_PLAY = 2'd1;
  localparam logic [1:0] KEY_SKIP = 2'd2;
  localparam logic [1:0] KEY_STOP = 2'd3;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLDOFF - 1);
  localparam logic [TRACK_W-1:0] TRACK_LAST = TRACK_W'(NUM_TRACKS - 1);
  localparam logic [SEC_W-1:0]   SEC_MAX    = {SEC_W{1'b1}};

  logic [7:0]         code_q;
  logic [1:0]         state_q, state_d;
  logic               muted_q, muted_d;
  logic [TRACK_W-1:0] track_q, track_d;
  logic [SEC_W-1:0]   elapsed_q, elapsed_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               start_q, start_d;
  logic               ack_q;
  logic               key_hit;

  // Only codes 0x00..0x03 are keys, and only once the holdoff window has drained.
  assign key_hit = (code_q[7:2] == 6'd0) && (hold_q == '0);

  always_comb begin
    state_d   = state_q;
    muted_d   = muted_q;
    track_d   = track_q;
    elapsed_d = elapsed_q;
    tick_d    = tick_q;
    start_d   = 1'b0;

    if (key_hit)
      hold_d = HOLD_LOAD;
    else if (hold_q != '0)
      hold_d = hold_q - 1'b1;
    else
      hold_d = hold_q;

    // Timer first; key actions below override it where they clear or restart.
    case (state_q)
      ST_PLAYING: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (elapsed_q != SEC_MAX)
            elapsed_d = elapsed_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_PAUSED: ;
      ST_STOPPED: tick_d = '0;
      default: begin
        state_d   = ST_STOPPED;
        tick_d    = '0;
        elapsed_d = '0;
      end
    endcase

    if (key_hit) begin
      case (code_q[1:0])
        KEY_MUTE: muted_d = ~muted_q;
        KEY_PLAY: begin
          if (state_q == ST_STOPPED) begin
            state_d   = ST_PLAYING;
            start_d   = 1'b1;
            elapsed_d = '0;
            tick_d    = '0;
          end else if (state_q == ST_PLAYING) begin
            state_d = ST_PAUSED;
          end else if (state_q == ST_PAUSED) begin
            state_d = ST_PLAYING;
          end
        end
        KEY_SKIP: begin
          track_d   = (track_q == TRACK_LAST) ? '0 : track_q + 1'b1;
          elapsed_d = '0;
          tick_d    = '0;
          start_d   = (state_q == ST_PLAYING);
        end
        default: begin
          state_d   = ST_STOPPED;
          elapsed_d = '0;
          tick_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= 8'hFF;
      state_q   <= ST_STOPPED;
      muted_q   <= 1'b0;
      track_q   <= '0;
      elapsed_q <= '0;
      tick_q    <= '0;
      hold_q    <= '0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      code_q    <= ir_code;
      state_q   <= state_d;
      muted_q   <= muted_d;
      track_q   <= track_d;
      elapsed_q <= elapsed_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      start_q   <= start_d;
      ack_q     <= key_hit;
    end
  end

  assign playing     = (state_q == ST_PLAYING);
  assign paused      = (state_q == ST_PAUSED);
  assign muted       = muted_q;
  assign track       = track_q;
  assign track_start = start_q;
  assign elapsed_s   = elapsed_q;
  assign key_ack     = ack_q;

endmodule

// File: tb/tb_ir_media_ctrl.sv
// Bench for ir_media_ctrl: directed scenarios then random key traffic, every cycle compared
// against a play-time based reference model.
module tb_ir_media_ctrl;

  localparam int NUM_TRACKS = 4;
  localparam int TICK_DIV   = 10;
  localparam int HOLDOFF    = 20;
  localparam int SEC_MAX    = 4095;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir_code;
  logic       playing, paused, muted, track_start, key_ack;
  logic [1:0] track;
  logic [11:0] elapsed_s;

  int tests = 0;
  int fails = 0;

  // Reference model: transport mode, and total cycles played on the current track.
  int m_mode;          // 0 stopped, 1 playing, 2 paused
  int m_muted, m_track, m_played, m_ack, m_start;
  int m_code, m_last_acc, m_edge;
  int ack_cnt;

  ir_media_ctrl #(
    .NUM_TRACKS(NUM_TRACKS), .TRACK_W(2), .TICK_DIV(TICK_DIV),
    .HOLDOFF(HOLDOFF), .SEC_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ir_code(ir_code),
    .playing(playing), .paused(paused), .muted(muted), .track(track),
    .track_start(track_start), .elapsed_s(elapsed_s), .key_ack(key_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_muted = 0; m_track = 0; m_played = 0;
    m_ack = 0; m_start = 0; m_code = 8'hFF; m_last_acc = -100000;
  endtask

  task automatic check_all();
    int secs;
    secs = m_played / TICK_DIV;
    if (secs > SEC_MAX) secs = SEC_MAX;
    chk("playing", 32'(playing), 32'(m_mode == 1));
    chk("paused", 32'(paused), 32'(m_mode == 2));
    chk("muted", 32'(muted), 32'(m_muted));
    chk("track", 32'(track), 32'(m_track));
    chk("track_start", 32'(track_start), 32'(m_start));
    chk("elapsed_s", 32'(elapsed_s), 32'(secs));
    chk("key_ack", 32'(key_ack), 32'(m_ack));
  endtask

  // One clock: apply code, advance the model by one edge, compare just after the edge.
  task automatic cyc(input int code);
    bit key;
    ir_code = 8'(code);
    @(posedge clk);
    m_edge++;
    key = (m_code <= 3) && (m_edge - m_last_acc >= HOLDOFF);
    m_ack = key; m_start = 0;
    if (key) begin
      m_last_acc = m_edge;
      case (m_code)
        0: begin m_muted ^= 1; if (m_mode == 1) m_played++; end
        1: begin
          if (m_mode == 0) begin m_mode = 1; m_played = 0; m_start = 1; end
          else if (m_mode == 1) begin m_mode = 2; m_played++; end
          else m_mode = 1;
        end
        2: begin
          m_track = (m_track + 1) % NUM_TRACKS;
          m_played = 0;
          m_start = (m_mode == 1);
        end
        default: begin m_mode = 0; m_played = 0; end
      endcase
    end else if (m_mode == 1) begin
      m_played++;
    end
    m_code = code;
    #1;
    if (key_ack === 1'b1) ack_cnt++;
    check_all();
  endtask

  task automatic press(input int code, input int idle);
    cyc(code);
    repeat (idle) cyc(8'hFF);
  endtask

  // Asynchronous reset between edges: outputs must clear before the next clock.
  task automatic mid_reset();
    #3 rst_n = 1'b0;
    ir_code = 8'hFF;
    #2;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int code, len;
    m_edge = 0; ack_cnt = 0;
    model_reset();
    rst_n = 1'b0;
    ir_code = 8'hFF;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // T2: single play press, then 35 played cycles -> 3 seconds
    press(8'h01, 36);
    chk("t2_elapsed", 32'(elapsed_s), 32'd3);

    // T3: held play key accepted once per holdoff window
    ack_cnt = 0;
    repeat (50) cyc(8'h01);
    repeat (5) cyc(8'hFF);
    chk("t3_ack_count", 32'(ack_cnt), 32'd3);
    chk("t3_paused", 32'(paused), 32'd1);
    repeat (20) cyc(8'hFF);

    // T4: resume, then four skips wrapping the track index
    press(8'h01, 25);
    for (int i = 1; i <= 4; i++) begin
      press(8'h02, 24);
      chk("t4_track", 32'(track), 32'(i % NUM_TRACKS));
    end
    repeat (30) cyc(8'hFF);
    mid_reset();
    chk("t1_track_after_reset", 32'(track), 32'd0);

    // T5: pause freezes, resume continues, stop clears time but keeps track
    press(8'h02, 24);
    press(8'h01, 24);
    chk("t5_elapsed_play", 32'(elapsed_s), 32'd2);
    press(8'h01, 30);
    chk("t5_elapsed_paused", 32'(elapsed_s), 32'd2);
    press(8'h01, 24);
    press(8'h03, 24);
    chk("t5_track_kept", 32'(track), 32'd1);
    chk("t5_stopped", 32'(playing), 32'd0);

    // T6: mute toggles; non-key codes never acknowledged
    press(8'h00, 24);
    chk("t6_muted", 32'(muted), 32'd1);
    ack_cnt = 0;
    repeat (100) cyc(8'h68);
    repeat (100) cyc(8'hFF);
    chk("t6_no_ack", 32'(ack_cnt), 32'd0);

    // Random key traffic with one asynchronous reset in the middle
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: code = 8'h00;
        1, 2: code = 8'h01;
        3: code = 8'h02;
        4: code = 8'h03;
        5: code = 8'h68;
        default: code = 8'hFF;
      endcase
      len = $urandom_range(1, 30);
      repeat (len) cyc(code);
      if (n == 150) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
